piso_tx_sched: RTL and testbench

Round-robin transmit scheduler that shares one 4-bit PISO shifter (clk, rst, load, parallel_in, serial_out) among NREQ requesters. It arbitrates pending words and drives the shifter's load/parallel_in. It then times the WIDTH serial bit cycles and a configurable inter-frame gap, and returns grant/done status. It sits between the requesting blocks and the piso instance in the serial-out path.

---
 rtl/piso_tx_sched.sv | 137 +++++++++++++
 tb/tb_piso_tx_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_sched.sv
// Round-robin transmit scheduler for a shared WIDTH-bit PISO shifter.
// Grants one pending requester, loads the shifter, then times the frame and inter-frame gap.
module piso_tx_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      piso_load,
  output logic [WIDTH-1:0]          piso_data,
  output logic                      frame_valid,
  output logic [$clog2(NREQ)-1:0]   active_id,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                state_dbg
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CMAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHIFT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_INIT   = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    win, idx;
  logic              found;
  logic              take;
  logic [NREQ-1:0]   gnt_d;
  logic              load_d, fv_d, done_d, busy_d;
  logic [WIDTH-1:0]  data_d;
  logic [IDW-1:0]    id_d;

  // Handshake: req is a level held until the requester sees its gnt pulse, and is
  // dropped on the following edge; a grant is a one-cycle pulse issued only from IDLE.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign take      = (state_q == S_IDLE) && found;
  assign state_dbg = state_q;

  // Next-state and counter/pointer logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LOAD;
          ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = SHIFT_INIT;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; piso_data/active_id hold until the next grant.
  always_comb begin
    gnt_d  = take ? (NREQ'(1) << win) : '0;
    load_d = take;
    data_d = take ? req_data[int'(win)*WIDTH +: WIDTH] : piso_data;
    id_d   = take ? win : active_id;
    fv_d   = (state_d == S_SHIFT);
    done_d = (state_q == S_SHIFT) && (cnt_q == '0);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt         <= '0;
      piso_load   <= 1'b0;
      piso_data   <= '0;
      frame_valid <= 1'b0;
      active_id   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt         <= gnt_d;
      piso_load   <= load_d;
      piso_data   <= data_d;
      frame_valid <= fv_d;
      active_id   <= id_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_tx_sched.sv
// Testbench for piso_tx_sched: directed scenarios plus random traffic against a
// cycle-level round-robin reference model, with a queue-based scoreboard monitor.
module tb_piso_tx_sched;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 4;
  localparam int GAP    = 1;
  localparam int IDW    = $clog2(NREQ);
  localparam int EW     = 32 + IDW + WIDTH;
  localparam int FRAME_PERIOD = 1 + 1 + WIDTH + GAP;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  piso_load;
  logic [WIDTH-1:0]      piso_data;
  logic                  frame_valid;
  logic [IDW-1:0]        active_id;
  logic                  busy;
  logic                  done;
  logic [1:0]            state_dbg;

  piso_tx_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .piso_load(piso_load), .piso_data(piso_data),
    .frame_valid(frame_valid), .active_id(active_id),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  logic [NREQ+WIDTH+IDW+5:0] outs_all;
  assign outs_all = {gnt, piso_load, piso_data, frame_valid, active_id, busy, done, state_dbg};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PISO shifter, MSB first.
  logic [WIDTH-1:0] sh;
  logic             serial_out;
  always @(posedge clk or posedge rst) begin
    if (rst)            sh <= '0;
    else if (piso_load) sh <= piso_data;
    else                sh <= sh << 1;
  end
  assign serial_out = sh[WIDTH-1];

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0]    exp_q[$];
  bit               mon_en = 1'b0;
  bit               fr_on  = 1'b0;
  int               since  = 0;
  logic [WIDTH-1:0] fr_word, col;
  logic [EW-1:0]    mon_e;
  logic [NREQ-1:0]  mon_g;

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      fr_on = 1'b0;
      since = 0;
    end else if (gnt != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", gnt, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_g = '0;
        mon_g[mon_e[WIDTH +: IDW]] = 1'b1;
        chk("grant_cycle", cyc, mon_e[EW-1 -: 32]);
        chk("gnt", gnt, mon_g);
        chk("piso_load", piso_load, 1);
        chk("piso_data", piso_data, mon_e[WIDTH-1:0]);
        chk("active_id", active_id, mon_e[WIDTH +: IDW]);
        chk("busy_load", busy, 1);
        chk("fv_load", frame_valid, 0);
        fr_on   = 1'b1;
        since   = 0;
        fr_word = mon_e[WIDTH-1:0];
        col     = '0;
      end
    end else begin
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
        mon_e = exp_q.pop_front();
        mon_g = '0;
        mon_g[mon_e[WIDTH +: IDW]] = 1'b1;
        chk("missing_gnt", gnt, mon_g);
      end
      chk("load_low", piso_load, 0);
      if (fr_on) begin
        since++;
        if (since <= WIDTH) begin
          chk("fv_shift", frame_valid, 1);
          chk("done_shift", done, 0);
          col = {col[WIDTH-2:0], serial_out};
        end else if (since == WIDTH + 1) begin
          chk("done_pulse", done, 1);
          chk("fv_end", frame_valid, 0);
          chk("serial_word", col, fr_word);
          chk("busy_done", busy, (GAP > 0) ? 1 : 0);
          if (GAP == 0) fr_on = 1'b0;
        end else if (since <= WIDTH + GAP) begin
          chk("busy_gap", busy, 1);
          chk("done_gap", done, 0);
        end else begin
          chk("busy_idle", busy, 0);
          chk("done_idle", done, 0);
          fr_on = 1'b0;
        end
      end else begin
        chk("quiet_fv", frame_valid, 0);
        chk("quiet_done", done, 0);
        chk("quiet_busy", busy, 0);
      end
    end
  end

  // ---------------- driver + reference model ----------------
  bit              rand_data = 1'b1;
  bit              rearm_en  = 1'b0;
  logic [NREQ-1:0] req_v     = '0;
  int              m_ptr     = 0;
  int              next_free = 0;
  int              pend_clr  = -1;
  int              age[NREQ] = '{default: 0};
  logic [NREQ-1:0] set_m, clr_m;

  // One cycle of requester behaviour; the model decides who wins the upcoming edge.
  task automatic step(input logic [NREQ-1:0] s_m, input logic [NREQ-1:0] c_m);
    int c, w;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (age[i] > 0) begin
        age[i]++;
        if (rearm_en && age[i] >= 3) begin
          req_v[i] = 1'b1;
          age[i]   = 0;
        end
      end
    end
    if (pend_clr >= 0) begin
      req_v[pend_clr] = 1'b0;
      age[pend_clr]   = 1;
      pend_clr        = -1;
    end
    req_v = (req_v & ~c_m) | s_m;
    if (rand_data)
      for (int i = 0; i < NREQ; i++)
        req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    req = req_v;
    c = cyc + 1;
    if (c >= next_free && req_v != '0) begin
      w = -1;
      for (int k = 0; k < NREQ && w < 0; k++)
        if (req_v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      exp_q.push_back({32'(c), IDW'(w), req_data[w*WIDTH +: WIDTH]});
      m_ptr     = (w + 1) % NREQ;
      next_free = c + FRAME_PERIOD;
      pend_clr  = w;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs_all, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", outs_all, 0);
    end
    mon_en = 1'b1;

    // single request, word 1 = 1011
    rand_data = 1'b0;
    req_data  = {4'h0, 4'h0, 4'hB, 4'h0};
    step(4'b0010, '0);
    repeat (10) step('0, '0);
    rand_data = 1'b1;

    // wrap-around priority
    step(4'b1000, '0);
    repeat (8) step('0, '0);
    step(4'b1001, '0);
    repeat (16) step('0, '0);

    // request changes while a frame is in flight
    step(4'b0010, '0);
    step('0, '0);
    step(4'b0100, '0);
    step('0, 4'b0100);
    step(4'b1000, '0);
    step('0, '0);
    step('0, 4'b1000);
    repeat (8) step('0, '0);

    // fairness with every requester re-arming two cycles after its grant
    rearm_en = 1'b1;
    step(4'b1111, '0);
    repeat (40) step('0, '0);
    rearm_en = 1'b0;
    repeat (12) step('0, '1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_m[i] = ($urandom_range(0, 3) == 0);
        clr_m[i] = ($urandom_range(0, 7) == 0);
      end
      step(set_m, clr_m);
    end
    repeat (12) step('0, '1);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_queue", exp_q.size(), 0);
    mon_en = 1'b0;

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    req      = 4'b0010;
    req_data = {4'h0, 4'h0, 4'h6, 4'h0};
    @(negedge clk);
    req = '0;
    chk("rst_pre_gnt", gnt, 4'b0010);
    @(negedge clk);
    chk("rst_pre_fv", frame_valid, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async", outs_all, 0);
    @(negedge clk);
    @(negedge clk);
    req      = 4'b0110;
    req_data = {4'h0, 4'h9, 4'h5, 4'h0};
    rst      = 1'b0;
    @(negedge clk);
    chk("rst_gnt", gnt, 4'b0010);
    chk("rst_id", active_id, 1);
    chk("rst_data", piso_data, 4'h5);
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "timeout");
  end

endmodule
